// File: rtl/mul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
//
// Contents:
//   - RV32 M-extension multiply op encodings (funct3[1:0])
//   - FSM state encoding
//   - Booth digit decode: partial-product magnitude select and sign
//
// Configuration macro used by the multiplier top: MUL_ZERO_BYPASS_EN
package mul_pkg;

    // Op encodings, equal to funct3[1:0] of the MUL* instructions
    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Partial-product magnitude selected by one Booth digit
    typedef enum logic [1:0] {
        PP_ZERO = 2'd0,
        PP_ONE  = 2'd1,
        PP_TWO  = 2'd2
    } pp_sel_t;

    typedef struct packed {
        logic    neg;
        pp_sel_t sel;
    } booth_dec_t;

    // Booth digit {b[1], b[0], b_prev}
    localparam logic [2:0] BOOTH_Z0  = 3'b000;
    localparam logic [2:0] BOOTH_P1A = 3'b001;
    localparam logic [2:0] BOOTH_P1B = 3'b010;
    localparam logic [2:0] BOOTH_P2  = 3'b011;
    localparam logic [2:0] BOOTH_M2  = 3'b100;
    localparam logic [2:0] BOOTH_M1A = 3'b101;
    localparam logic [2:0] BOOTH_M1B = 3'b110;
    localparam logic [2:0] BOOTH_Z1  = 3'b111;

    function automatic booth_dec_t booth_decode(input logic [2:0] digit);
        booth_dec_t d;
        d.neg = 1'b0;
        d.sel = PP_ZERO;
        case (digit)
            BOOTH_P1A, BOOTH_P1B: begin d.neg = 1'b0; d.sel = PP_ONE; end
            BOOTH_P2:             begin d.neg = 1'b0; d.sel = PP_TWO; end
            BOOTH_M2:             begin d.neg = 1'b1; d.sel = PP_TWO; end
            BOOTH_M1A, BOOTH_M1B: begin d.neg = 1'b1; d.sel = PP_ONE; end
            default:              begin d.neg = 1'b0; d.sel = PP_ZERO; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_mul_seq_cla.sv
// Carry-lookahead adder, WIDTH bits, sum = a + b + cin (carry-out dropped).
// Carries are resolved by lookahead inside 4-bit groups; group carries
// chain from one group to the next. A short final group is allowed.
//
// Ports:
//   a    in  WIDTH  addend
//   b    in  WIDTH  addend
//   cin  in  1      carry in
//   sum  out WIDTH  a + b + cin, modulo 2**WIDTH
module booth_mul_seq_cla #(
    parameter int WIDTH = 36
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    logic carry;
    logic blk_cin;
    logic grp_g;
    logic grp_p;

    always_comb begin
        sum     = '0;
        carry   = cin;
        blk_cin = cin;
        grp_g   = 1'b0;
        grp_p   = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            // New group: capture the carry entering it, restart group G/P
            if ((i % 4) == 0) begin
                blk_cin = carry;
                grp_g   = 1'b0;
                grp_p   = 1'b1;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            // Prefix generate/propagate from group start up to bit i
            grp_g  = (a[i] & b[i]) | ((a[i] ^ b[i]) & grp_g);
            grp_p  = (a[i] ^ b[i]) & grp_p;
            carry  = grp_g | (grp_p & blk_cin);
        end
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier for RV32 MUL/MULH/MULHSU/MULHU.
// One Booth digit is retired per cycle through a single shared CLA adder.
//
// Ports:
//   clk         in   1     clock, rising edge
//   rst_n       in   1     asynchronous active-low reset
//   req_valid   in   1     request present
//   req_ready   out  1     request accepted when high (IDLE only)
//   req_op      in   2     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_a       in   XLEN  rs1 (multiplicand)
//   req_b       in   XLEN  rs2 (multiplier)
//   kill        in   1     synchronous abort, drops any operation in flight
//   resp_valid  out  1     result present
//   resp_ready  in   1     consumer takes result
//   resp_data   out  XLEN  result
//   busy        out  1     operation in flight or result pending
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high and kill is low; a response transfers on a
// rising edge where resp_valid and resp_ready are both high and kill is low.
// resp_valid/resp_data stay stable until that transfer.
//
// Configuration macro:
//   MUL_ZERO_BYPASS_EN  when defined, a request with a zero operand goes
//                       straight to DONE with a zero result.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int EXTW = XLEN + 2;
    localparam int ITER = EXTW / 2;
    localparam int ADDW = EXTW + 2;
    localparam int CNTW = $clog2(ITER + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ITER - 1);

    state_t state, state_next;

    logic [1:0]      op;
    logic [EXTW-1:0] a_ext;
    logic [EXTW-1:0] b;
    logic [ADDW-1:0] acc;
    logic            b_prev;
    logic [CNTW-1:0] cnt;

    logic            accept;
    logic            zero_op;
    logic            a_signed;
    logic            b_signed;
    logic [EXTW-1:0] req_a_ext;
    logic [EXTW-1:0] req_b_ext;

    booth_dec_t      dec;
    logic [ADDW-1:0] pp_mag;
    logic [ADDW-1:0] pp_add;
    logic [ADDW-1:0] sum;
    logic [ADDW-1:0] acc_sh;
    logic [EXTW-1:0] b_sh;
    logic [XLEN-1:0] res_lo;
    logic [XLEN-1:0] res_hi;

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (req_a == '0) || (req_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // kill has priority over a new request in IDLE
    assign accept = (state == ST_IDLE) && req_valid && !kill;

    // Operand extension: MUL/MULH both signed, MULHSU a signed only, MULHU none
    assign a_signed  = (req_op != MUL_OP_MULHU);
    assign b_signed  = (req_op == MUL_OP_MUL) || (req_op == MUL_OP_MULH);
    assign req_a_ext = {{(EXTW-XLEN){a_signed & req_a[XLEN-1]}}, req_a};
    assign req_b_ext = {{(EXTW-XLEN){b_signed & req_b[XLEN-1]}}, req_b};

    // ---------------------------------------------------------------
    // Booth step datapath
    // ---------------------------------------------------------------
    assign dec = booth_decode({b[1:0], b_prev});

    always_comb begin
        pp_mag = '0;
        case (dec.sel)
            PP_ONE:  pp_mag = {{(ADDW-EXTW){a_ext[EXTW-1]}}, a_ext};
            PP_TWO:  pp_mag = {a_ext[EXTW-1], a_ext, 1'b0};
            default: pp_mag = '0;
        endcase
    end

    // Negative digits subtract: add the inverted magnitude with carry-in 1
    assign pp_add = dec.neg ? ~pp_mag : pp_mag;

    booth_mul_seq_cla #(
        .WIDTH (ADDW)
    ) u_cla (
        .a   (acc),
        .b   (pp_add),
        .cin (dec.neg),
        .sum (sum)
    );

    // {acc, b} arithmetic shift right by 2 after the add
    assign acc_sh = {{2{sum[ADDW-1]}}, sum[ADDW-1:2]};
    assign b_sh   = {sum[1:0], b[EXTW-1:2]};

    // Product is the low 2*XLEN bits of the shifted {acc, b}
    assign res_lo = b_sh[XLEN-1:0];
    assign res_hi = {acc_sh[2*XLEN-EXTW-1:0], b_sh[EXTW-1:XLEN]};

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = zero_op ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_next = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (kill || resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_DONE);
        busy       = (state != ST_IDLE);
    end

    // ---------------------------------------------------------------
    // Operand / accumulator registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op        <= MUL_OP_MUL;
            a_ext     <= '0;
            b         <= '0;
            acc       <= '0;
            b_prev    <= 1'b0;
            cnt       <= '0;
            resp_data <= '0;
        end else if (accept) begin
            op     <= req_op;
            a_ext  <= req_a_ext;
            b      <= req_b_ext;
            acc    <= '0;
            b_prev <= 1'b0;
            cnt    <= '0;
            if (zero_op) begin
                resp_data <= '0;
            end
        end else if ((state == ST_CALC) && !kill) begin
            acc    <= acc_sh;
            b      <= b_sh;
            b_prev <= b[1];
            cnt    <= cnt + CNTW'(1);
            if (cnt == CNT_LAST) begin
                resp_data <= (op == MUL_OP_MUL) ? res_lo : res_hi;
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq. Results are compared against a
// 64-bit arithmetic reference product computed from the op's signedness.
// Build with or without +define+MUL_ZERO_BYPASS_EN.
module tb_booth_mul_seq;

    localparam int XLEN    = 32;
    localparam int LAT     = 18;
    localparam int MAX_LAT = 100;
    localparam int N_RAND  = 1500;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            busy;

    int n_checks;
    int n_fail;

    booth_mul_seq #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic [63:0] ea, eb, p;
        logic sa, sb;
        sa = (op != 2'b11);
        sb = (op == 2'b00) || (op == 2'b01);
        ea = (sa && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        eb = (sb && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int ref_lat(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
`ifdef MUL_ZERO_BYPASS_EN
        return (a == 0 || b == 0) ? 1 : LAT;
`else
        if (a == 0 && b == 0) return LAT;
        return LAT;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // Issues one request (DUT must be idle), scrambles the operand inputs
    // after the accept edge, and waits for resp_valid. lat counts rising
    // edges from the accept edge (inclusive) until resp_valid is seen.
    task automatic start_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 3));
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic wait_resp(output int lat, output bit timeout);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < MAX_LAT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        timeout = (resp_valid !== 1'b1);
    endtask

    task automatic take_resp(input int hold);
        repeat (hold) @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input int hold,
                          output logic [XLEN-1:0] data, output int lat,
                          output bit timeout);
        start_op(op, a, b);
        wait_resp(lat, timeout);
        data = resp_data;
        take_resp(hold);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [1:0]      dir_op [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [XLEN-1:0] dir_a  [5] = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [XLEN-1:0] dir_b  [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [XLEN-1:0] dir_e  [5] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};

    task automatic test_directed;
        logic [XLEN-1:0] d;
        int lat;
        bit to;
        for (int i = 0; i < 5; i++) begin
            run_op(dir_op[i], dir_a[i], dir_b[i], 0, d, lat, to);
            n_checks++;
            if (to) begin n_fail++; $display("FAIL directed_timeout[%0d] no resp_valid within %0d cycles", i, MAX_LAT); end
            n_checks++;
            if (d !== dir_e[i]) begin n_fail++; $display("FAIL directed_data[%0d] got %h want %h", i, d, dir_e[i]); end
            n_checks++;
            if (lat != LAT) begin n_fail++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, LAT); end
        end
    endtask

    task automatic test_backpressure;
        logic [XLEN-1:0] a, b, e;
        int lat;
        bit to;
        a = $urandom | 32'h1;
        b = $urandom | 32'h1;
        e = ref_mul(2'b10, a, b);
        start_op(2'b10, a, b);
        wait_resp(lat, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL bp_timeout no resp_valid within %0d cycles", MAX_LAT); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (resp_valid !== 1'b1 || resp_data !== e || req_ready !== 1'b0)
            begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got valid=%b data=%h ready=%b want 1 %h 0",
                         i, resp_valid, resp_data, req_ready, e);
            end
            @(posedge clk);
            #1;
        end
        take_resp(0);
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release got valid=%b ready=%b busy=%b want 0 1 0", resp_valid, req_ready, busy);
        end
    endtask

    task automatic test_kill;
        logic [XLEN-1:0] d, a, b;
        int lat;
        bit to;
        bit seen;
        // kill while computing, at cnt=8
        start_op(2'b11, $urandom | 32'h1, $urandom | 32'h1);
        repeat (8) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_calc got ready=%b busy=%b valid=%b want 1 0 0", req_ready, busy, resp_valid);
        end
        seen = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL kill_no_resp got resp_valid=1 want 0"); end

        // kill in DONE wins over resp_ready
        start_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF1);
        wait_resp(lat, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL kill_done_timeout no resp_valid within %0d cycles", MAX_LAT); end
        kill       = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        kill       = 1'b0;
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_done got valid=%b busy=%b want 0 0", resp_valid, busy);
        end

        // kill in IDLE blocks the request
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_a     = 32'h5;
        req_b     = 32'h3;
        kill      = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        kill      = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_idle got busy=%b valid=%b want 0 0", busy, resp_valid);
        end

        // a normal op after kills still computes correctly
        a = $urandom;
        b = $urandom;
        run_op(2'b01, a, b, 0, d, lat, to);
        n_checks++;
        if (to || d !== ref_mul(2'b01, a, b)) begin
            n_fail++;
            $display("FAIL kill_recover got %h want %h (timeout=%0d)", d, ref_mul(2'b01, a, b), to);
        end
    endtask

    task automatic test_reset_mid;
        logic [XLEN-1:0] d, a, b;
        int lat;
        bit to;
        start_op(2'b00, 32'hDEAD_BEEF, 32'h0000_0003);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== '0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid got valid=%b busy=%b data=%h ready=%b want 0 0 0 1",
                     resp_valid, busy, resp_data, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = $urandom;
        b = $urandom;
        run_op(2'b10, a, b, 0, d, lat, to);
        n_checks++;
        if (to || d !== ref_mul(2'b10, a, b) || lat != LAT) begin
            n_fail++;
            $display("FAIL reset_recover got %h lat %0d want %h lat %0d", d, lat, ref_mul(2'b10, a, b), LAT);
        end
    endtask

    task automatic test_zero_operand;
        logic [XLEN-1:0] d;
        int lat;
        bit to;
        run_op(2'b01, 32'h0, 32'hFFFF_FFFF, 0, d, lat, to);
        n_checks++;
        if (to || d !== 32'h0) begin n_fail++; $display("FAIL zero_a_data got %h want 0", d); end
        n_checks++;
        if (lat != ref_lat(32'h0, 32'hFFFF_FFFF)) begin
            n_fail++;
            $display("FAIL zero_a_latency got %0d want %0d", lat, ref_lat(32'h0, 32'hFFFF_FFFF));
        end
        run_op(2'b00, 32'h8000_0001, 32'h0, 2, d, lat, to);
        n_checks++;
        if (to || d !== 32'h0) begin n_fail++; $display("FAIL zero_b_data got %h want 0", d); end
        n_checks++;
        if (lat != ref_lat(32'h8000_0001, 32'h0)) begin
            n_fail++;
            $display("FAIL zero_b_latency got %0d want %0d", lat, ref_lat(32'h8000_0001, 32'h0));
        end
    endtask

    function automatic logic [XLEN-1:0] rand_operand();
        case ($urandom_range(0, 15))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random;
        logic [XLEN-1:0] a, b, d, e;
        logic [1:0] op;
        int lat, bad_data, bad_lat;
        bit to;
        bad_data = 0;
        bad_lat  = 0;
        for (int i = 0; i < N_RAND; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = rand_operand();
            b  = rand_operand();
            e  = ref_mul(op, a, b);
            run_op(op, a, b, $urandom_range(0, 2), d, lat, to);
            n_checks++;
            if (to || d !== e) begin
                n_fail++;
                bad_data++;
                if (bad_data <= 10)
                    $display("FAIL random_data[%0d] op=%0d a=%h b=%h got %h want %h", i, op, a, b, d, e);
            end
            n_checks++;
            if (lat != ref_lat(a, b)) begin
                n_fail++;
                bad_lat++;
                if (bad_lat <= 10)
                    $display("FAIL random_latency[%0d] a=%h b=%h got %0d want %0d", i, a, b, lat, ref_lat(a, b));
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        kill       = 1'b0;
        resp_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_kill();
        test_reset_mid();
        test_zero_operand();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
